rgb_byte_sequencer: RTL

- Upstream stage of the display byte path.
- Accepts one 24-bit pixel (8-bit R, G, B) per valid/ready handshake and holds the three channel registers.
- Drives one-hot channel selects so the downstream byte mux emits R, then G, then B as successive bytes.
- Paces each byte with a ByteValid/ByteReady handshake toward the byte sink, and optionally inserts blanking gap cycles between pixels.

---
 rtl/display_pkg.sv | 36 +++
 rtl/rgb_byte_sequencer_gap_timer.sv | 31 +++
 rtl/rgb_byte_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared display byte-path definitions: sequencer states, channel defaults and
// the one-hot channel select encoding ({SelR, SelG, SelB}).
package display_pkg;

   localparam int unsigned CH_W_DEF = 8;
   localparam int unsigned STATE_W  = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      SEND_R = 3'd1,
      SEND_G = 3'd2,
      SEND_B = 3'd3,
      GAP    = 3'd4
   } seq_state_t;

   localparam logic [2:0] SEL_R    = 3'b100;
   localparam logic [2:0] SEL_G    = 3'b010;
   localparam logic [2:0] SEL_B    = 3'b001;
   localparam logic [2:0] SEL_NONE = 3'b000;

   // One-hot select driven to the byte mux while in a given state.
   function automatic logic [2:0] sel_for_state(input logic [STATE_W-1:0] s);
      case (s)
         SEND_R:  return SEL_R;
         SEND_G:  return SEL_G;
         SEND_B:  return SEL_B;
         default: return SEL_NONE;
      endcase
   endfunction

   // True for the three byte-emitting states.
   function automatic logic is_send(input logic [STATE_W-1:0] s);
      return (s == SEND_R) || (s == SEND_G) || (s == SEND_B);
   endfunction

endpackage

// File: rtl/rgb_byte_sequencer_gap_timer.sv
// seq_gap_timer: loadable down-counter that times the blanking gap between
// pixels. done_c is high while the count sits at zero.
module seq_gap_timer
   import display_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         done_c
);

   logic [W-1:0] count;

   // Load has priority; decrement saturates at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign done_c = (count == '0);

endmodule

// File: rtl/rgb_byte_sequencer.sv
// rgb_byte_sequencer: accepts one RGB pixel per handshake and walks the
// downstream byte mux through its three channels with a ByteValid/ByteReady
// handshake, optionally followed by GAP_CYCLES blanking cycles.
// Build option: define ORDER_BGR_EN to emit B, G, R instead of R, G, B.
module rgb_byte_sequencer
   import display_pkg::*;
#(
   parameter int unsigned CH_W       = CH_W_DEF,
   parameter int unsigned GAP_CYCLES = 0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             PixValid,
   output logic             PixReady,
   input  logic [CH_W-1:0]  PixR,
   input  logic [CH_W-1:0]  PixG,
   input  logic [CH_W-1:0]  PixB,
   output logic [CH_W-1:0]  R,
   output logic [CH_W-1:0]  G,
   output logic [CH_W-1:0]  B,
   output logic             SelR,
   output logic             SelG,
   output logic             SelB,
   output logic             ByteValid,
   input  logic             ByteReady,
   output logic             Busy,
   output logic [CNT_W-1:0] PixCount
);

   localparam int unsigned GAP_W = 8;

   localparam logic [STATE_W-1:0] S_IDLE   = IDLE;
   localparam logic [STATE_W-1:0] S_SEND_R = SEND_R;
   localparam logic [STATE_W-1:0] S_SEND_G = SEND_G;
   localparam logic [STATE_W-1:0] S_SEND_B = SEND_B;
   localparam logic [STATE_W-1:0] S_GAP    = GAP;

`ifdef ORDER_BGR_EN
   localparam logic [STATE_W-1:0] S_FIRST = S_SEND_B;
   localparam logic [STATE_W-1:0] S_LAST  = S_SEND_R;
`else
   localparam logic [STATE_W-1:0] S_FIRST = S_SEND_R;
   localparam logic [STATE_W-1:0] S_LAST  = S_SEND_B;
`endif

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic               take_pix;
   logic               count_inc;
   logic               gap_load;
   logic               gap_dec;
   logic               gap_done;
   logic [2:0]         sel_q;

   // Ready in IDLE, or on the last byte's acceptance when pixels run back-to-back.
   assign PixReady = !Reset &&
                     ((state == S_IDLE) ||
                      ((GAP_CYCLES == 0) && (state == S_LAST) && ByteReady));

   assign {SelR, SelG, SelB} = sel_q;

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control strobes.
   always_comb begin
      state_nxt = state;
      take_pix  = 1'b0;
      count_inc = 1'b0;
      gap_load  = 1'b0;
      gap_dec   = 1'b0;
      case (state)
         S_IDLE: begin
            if (PixValid) begin
               take_pix  = 1'b1;
               state_nxt = S_FIRST;
            end
         end
         S_SEND_R, S_SEND_G, S_SEND_B: begin
            if (ByteReady) begin
               if (state == S_LAST) begin
                  count_inc = 1'b1;
                  if (GAP_CYCLES == 0) begin
                     if (PixValid) begin
                        take_pix  = 1'b1;
                        state_nxt = S_FIRST;
                     end else begin
                        state_nxt = S_IDLE;
                     end
                  end else begin
                     gap_load  = 1'b1;
                     state_nxt = S_GAP;
                  end
               end else if (state == S_FIRST) begin
                  state_nxt = S_SEND_G;
               end else begin
                  state_nxt = S_LAST;
               end
            end
         end
         S_GAP: begin
            if (gap_done) begin
               state_nxt = S_IDLE;
            end else begin
               gap_dec = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Registered outputs follow the state being entered.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         R         <= '0;
         G         <= '0;
         B         <= '0;
         sel_q     <= SEL_NONE;
         ByteValid <= 1'b0;
         Busy      <= 1'b0;
         PixCount  <= '0;
      end else begin
         sel_q     <= sel_for_state(state_nxt);
         ByteValid <= is_send(state_nxt);
         Busy      <= (state_nxt != S_IDLE);
         if (take_pix) begin
            R <= PixR;
            G <= PixG;
            B <= PixB;
         end
         if (count_inc) begin
            PixCount <= PixCount + CNT_W'(1);
         end
      end
   end

   // Gap timer exists only when blanking is configured.
   generate
      if (GAP_CYCLES > 0) begin : g_gap
         localparam logic [GAP_W-1:0] LOAD_V = GAP_W'(GAP_CYCLES - 1);
         seq_gap_timer #(.W(GAP_W)) u_gap_timer (
            .clk        (Clk),
            .rst        (Reset),
            .load       (gap_load),
            .load_value (LOAD_V),
            .dec        (gap_dec),
            .done_c     (gap_done)
         );
      end else begin : g_no_gap
         logic unused_gap_ctl;
         assign unused_gap_ctl = gap_load ^ gap_dec;
         assign gap_done       = 1'b1;
      end
   endgenerate

endmodule
